// File: rtl/decode_issue_pkg.sv
// Shared processor constants and small helpers for the decode/issue stage.
package decode_issue_pkg;

    localparam int REG_W  = 3;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One pending register write travelling down the pipe
    typedef struct packed {
        logic             v;
        logic             we;
        logic [REG_W-1:0] rd;
    } wr_slot_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX) begin
            return val;
        end else begin
            return val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/decode_issue_reg_match.sv
// Compares one source register select against the writes still pending in EX and MEM.
import decode_issue_pkg::*;

module reg_match (
    input  logic             ex_valid,
    input  logic             ex_we,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_v,
    input  logic             mem_we,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] r,
    output logic             hit
);

    // r0 is an ordinary register here, so no zero-register exemption
    always_comb begin
        hit = (ex_valid & ex_we & (ex_rd == r)) |
              (mem_v & mem_we & (mem_rd == r));
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: RAW interlock against EX/MEM writes, EX latch, stall counter.
import decode_issue_pkg::*;

module decode_issue (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_we,
    input  logic [DATA_W-1:0] rf_read1data,
    input  logic [DATA_W-1:0] rf_read2data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic [REG_W-1:0]  rf_read1regsel,
    output logic [REG_W-1:0]  rf_read2regsel,
    output logic              id_stall,
    output logic              ex_valid,
    output logic              ex_we,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [CNT_W-1:0]  perf_stalls
);

    logic              ex_valid_r;
    logic              ex_we_r;
    logic [REG_W-1:0]  ex_rd_r;
    logic [DATA_W-1:0] ex_op1_r;
    logic [DATA_W-1:0] ex_op2_r;
    wr_slot_t          mem_slot_r;
    logic [CNT_W-1:0]  perf_stalls_r;

    logic              hit_rs_s;
    logic              hit_rt_s;
    logic              hazard_s;
    logic              issue_s;
    logic              count_s;

    reg_match u_match_rs (
        .ex_valid (ex_valid_r),
        .ex_we    (ex_we_r),
        .ex_rd    (ex_rd_r),
        .mem_v    (mem_slot_r.v),
        .mem_we   (mem_slot_r.we),
        .mem_rd   (mem_slot_r.rd),
        .r        (id_rs),
        .hit      (hit_rs_s)
    );

    reg_match u_match_rt (
        .ex_valid (ex_valid_r),
        .ex_we    (ex_we_r),
        .ex_rd    (ex_rd_r),
        .mem_v    (mem_slot_r.v),
        .mem_we   (mem_slot_r.we),
        .mem_rd   (mem_slot_r.rd),
        .r        (id_rt),
        .hit      (hit_rt_s)
    );

    // Hazard detection and the issue / stall-count decisions; flush overrides both
    always_comb begin
        hazard_s = 1'b0;
        issue_s  = 1'b0;
        count_s  = 1'b0;
        hazard_s = id_valid & ((id_use_rs & hit_rs_s) | (id_use_rt & hit_rt_s));
        if (flush) begin
            issue_s = 1'b0;
            count_s = 1'b0;
        end else begin
            issue_s = id_valid & ~hazard_s;
            count_s = hazard_s;
        end
    end

    // Pipeline registers and counter; everything freezes while EX/MEM holds
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r    <= 1'b0;
            ex_we_r       <= 1'b0;
            ex_rd_r       <= {REG_W{1'b0}};
            ex_op1_r      <= {DATA_W{1'b0}};
            ex_op2_r      <= {DATA_W{1'b0}};
            mem_slot_r    <= '{v: 1'b0, we: 1'b0, rd: {REG_W{1'b0}}};
            perf_stalls_r <= {CNT_W{1'b0}};
        end else if (!ex_stall) begin
            mem_slot_r <= '{v: ex_valid_r, we: ex_we_r, rd: ex_rd_r};
            if (issue_s) begin
                ex_valid_r <= 1'b1;
                ex_we_r    <= id_we;
                ex_rd_r    <= id_rd;
                ex_op1_r   <= rf_read1data;
                ex_op2_r   <= rf_read2data;
            end else begin
                // Bubble: only the valid/write-enable bits clear, payload holds
                ex_valid_r <= 1'b0;
                ex_we_r    <= 1'b0;
            end
            if (count_s) begin
                perf_stalls_r <= sat_inc(perf_stalls_r);
            end else begin
                perf_stalls_r <= perf_stalls_r;
            end
        end else begin
            ex_valid_r    <= ex_valid_r;
            mem_slot_r    <= mem_slot_r;
            perf_stalls_r <= perf_stalls_r;
        end
    end

    // Output wiring: read selects pass through, EX view comes straight from registers
    always_comb begin
        rf_read1regsel = id_rs;
        rf_read2regsel = id_rt;
        id_stall       = hazard_s | ex_stall;
        ex_valid       = ex_valid_r;
        ex_we          = ex_we_r;
        ex_rd          = ex_rd_r;
        ex_op1         = ex_op1_r;
        ex_op2         = ex_op2_r;
        perf_stalls    = perf_stalls_r;
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: each task drives a scenario and checks inline.
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [2:0]  id_rd;
    logic        id_we;
    logic [15:0] rf_read1data;
    logic [15:0] rf_read2data;
    logic        ex_stall;
    logic        flush;
    logic [2:0]  rf_read1regsel;
    logic [2:0]  rf_read2regsel;
    logic        id_stall;
    logic        ex_valid;
    logic        ex_we;
    logic [2:0]  ex_rd;
    logic [15:0] ex_op1;
    logic [15:0] ex_op2;
    logic [15:0] perf_stalls;

    int total;
    int bad;

    decode_issue dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .id_rd          (id_rd),
        .id_we          (id_we),
        .rf_read1data   (rf_read1data),
        .rf_read2data   (rf_read2data),
        .ex_stall       (ex_stall),
        .flush          (flush),
        .rf_read1regsel (rf_read1regsel),
        .rf_read2regsel (rf_read2regsel),
        .id_stall       (id_stall),
        .ex_valid       (ex_valid),
        .ex_we          (ex_we),
        .ex_rd          (ex_rd),
        .ex_op1         (ex_op1),
        .ex_op2         (ex_op2),
        .perf_stalls    (perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one ID instruction and let combinational outputs settle
    task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic urs, input logic urt, input logic [2:0] rd,
                         input logic we, input logic [15:0] d1, input logic [15:0] d2);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_rd        = rd;
        id_we        = we;
        rf_read1data = d1;
        rf_read2data = d2;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic drain();
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_stall = 1'b1; flush = 1'b1;
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd1, 1'b1, 16'h5555, 16'h6666);
        tick();
        tick();
        rst = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        // Every source matches r0 but nothing is pending after reset
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 16'h0101, 16'h0202);
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%0h want=0", ex_valid); end
        total++; if (ex_we !== 1'b0) begin bad++; $display("FAIL rst_ex_we got=%0h want=0", ex_we); end
        total++; if (ex_rd !== 3'd0) begin bad++; $display("FAIL rst_ex_rd got=%0h want=0", ex_rd); end
        total++; if (ex_op1 !== 16'h0000 || ex_op2 !== 16'h0000) begin bad++; $display("FAIL rst_ops got=%h/%h want=0000/0000", ex_op1, ex_op2); end
        total++; if (perf_stalls !== 16'h0000) begin bad++; $display("FAIL rst_perf got=%h want=0000", perf_stalls); end
        total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL rst_no_hazard got=%0h want=0", id_stall); end
        drive(1'b0, 3'd6, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
        total++; if (rf_read1regsel !== 3'd6 || rf_read2regsel !== 3'd3) begin bad++; $display("FAIL regsel got=%0d/%0d want=6/3", rf_read1regsel, rf_read2regsel); end
        drain();
    endtask

    task automatic test_independent();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 16'h1111, 16'h2222);
        tick();
        drive(1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 3'd6, 1'b1, 16'h1234, 16'hABCD);
        total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL indep_stall got=%0h want=0", id_stall); end
        tick();
        total++; if (ex_valid !== 1'b1 || ex_we !== 1'b1 || ex_rd !== 3'd6) begin bad++; $display("FAIL indep_ctl got=%0h/%0h/%0d want=1/1/6", ex_valid, ex_we, ex_rd); end
        total++; if (ex_op1 !== 16'h1234 || ex_op2 !== 16'hABCD) begin bad++; $display("FAIL indep_ops got=%h/%h want=1234/abcd", ex_op1, ex_op2); end
        drain();
    endtask

    task automatic test_raw1();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0055, 16'h0066);
        tick();
        drive(1'b1, 3'd5, 3'd2, 1'b1, 1'b1, 3'd7, 1'b1, 16'h7777, 16'h8888);
        total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL raw1_stall_c0 got=%0h want=1", id_stall); end
        tick();
        total++; if (ex_valid !== 1'b0 || perf_stalls !== 16'd1) begin bad++; $display("FAIL raw1_bubble1 got=%0h/%h want=0/0001", ex_valid, perf_stalls); end
        total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL raw1_stall_c1 got=%0h want=1", id_stall); end
        tick();
        total++; if (ex_valid !== 1'b0 || id_stall !== 1'b0) begin bad++; $display("FAIL raw1_bubble2 got=%0h/%0h want=0/0", ex_valid, id_stall); end
        tick();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd7 || ex_op1 !== 16'h7777) begin bad++; $display("FAIL raw1_issue got=%0h/%0d/%h want=1/7/7777", ex_valid, ex_rd, ex_op1); end
        total++; if (perf_stalls !== 16'd2) begin bad++; $display("FAIL raw1_perf got=%h want=0002", perf_stalls); end
        drain();
    endtask

    task automatic test_raw2_unused();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0055, 16'h0066);
        tick();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0011, 16'h0022);
        total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL raw2_between got=%0h want=0", id_stall); end
        tick();
        drive(1'b1, 3'd3, 3'd5, 1'b1, 1'b1, 3'd2, 1'b1, 16'h3333, 16'h4444);
        total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL raw2_stall got=%0h want=1", id_stall); end
        tick();
        total++; if (id_stall !== 1'b0 || perf_stalls !== 16'd3) begin bad++; $display("FAIL raw2_one got=%0h/%h want=0/0003", id_stall, perf_stalls); end
        tick();
        total++; if (ex_valid !== 1'b1 || ex_op2 !== 16'h4444) begin bad++; $display("FAIL raw2_issue got=%0h/%h want=1/4444", ex_valid, ex_op2); end
        drain();
        // Matching rt that is not actually read
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0055, 16'h0066);
        tick();
        drive(1'b1, 3'd1, 3'd5, 1'b1, 1'b0, 3'd2, 1'b1, 16'h9999, 16'hAAAA);
        total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL unused_rt got=%0h want=0", id_stall); end
        tick();
        total++; if (ex_valid !== 1'b1 || perf_stalls !== 16'd3) begin bad++; $display("FAIL unused_issue got=%0h/%h want=1/0003", ex_valid, perf_stalls); end
        drain();
        // A non-writing producer never blocks a reader of its rd
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b0, 16'h0055, 16'h0066);
        tick();
        drive(1'b1, 3'd5, 3'd5, 1'b1, 1'b1, 3'd2, 1'b1, 16'h9999, 16'hAAAA);
        total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL we0_producer got=%0h want=0", id_stall); end
        drain();
    endtask

    task automatic test_ex_stall();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 16'h00A1, 16'h00A2);
        tick();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd6, 1'b1, 16'h00B1, 16'h00B2);
        tick();
        // Consumer of r5 while r5's producer sits in MEM and EX/MEM is held
        ex_stall = 1'b1;
        drive(1'b1, 3'd5, 3'd1, 1'b1, 1'b0, 3'd7, 1'b1, 16'h00C1, 16'h00C2);
        for (int i = 0; i < 3; i++) begin
            total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d] got=%0h want=1", i, id_stall); end
            tick();
            total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd6 || ex_op1 !== 16'h00B1 || perf_stalls !== 16'd3) begin
                bad++; $display("FAIL hold_frozen[%0d] got=%0h/%0d/%h/%h want=1/6/00b1/0003", i, ex_valid, ex_rd, ex_op1, perf_stalls);
            end
        end
        ex_stall = 1'b0;
        #1;
        total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL hold_mem_kept got=%0h want=1", id_stall); end
        tick();
        total++; if (id_stall !== 1'b0 || ex_valid !== 1'b0 || perf_stalls !== 16'd4) begin bad++; $display("FAIL hold_release got=%0h/%0h/%h want=0/0/0004", id_stall, ex_valid, perf_stalls); end
        tick();
        total++; if (ex_valid !== 1'b1 || ex_op1 !== 16'h00C1) begin bad++; $display("FAIL hold_issue got=%0h/%h want=1/00c1", ex_valid, ex_op1); end
        drain();
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 16'h0F0F, 16'hF0F0);
        tick();
        flush = 1'b0;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_squash got=%0h want=0", ex_valid); end
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 16'h00D1, 16'h00D2);
        tick();
        flush = 1'b1; ex_stall = 1'b1;
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd4, 1'b1, 16'h00E1, 16'h00E2);
        tick();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd3 || ex_op1 !== 16'h00D1) begin bad++; $display("FAIL flush_held got=%0h/%0d/%h want=1/3/00d1", ex_valid, ex_rd, ex_op1); end
        flush = 1'b0; ex_stall = 1'b0;
        drain();
        // Flush against a live hazard: squashed, not counted
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0055, 16'h0066);
        tick();
        flush = 1'b1;
        drive(1'b1, 3'd5, 3'd2, 1'b1, 1'b1, 3'd7, 1'b1, 16'h7777, 16'h8888);
        tick();
        flush = 1'b0;
        total++; if (ex_valid !== 1'b0 || perf_stalls !== 16'd4) begin bad++; $display("FAIL flush_hazard got=%0h/%h want=0/0004", ex_valid, perf_stalls); end
        drain();
    endtask

    task automatic preload_perf();
        force dut.perf_stalls_r = 16'hFFFE;
        #1;
        release dut.perf_stalls_r;
        #1;
    endtask

    task automatic test_reset_mid_stall();
        preload_perf();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0055, 16'h0066);
        tick();
        total++; if (perf_stalls !== 16'hFFFE) begin bad++; $display("FAIL preload got=%h want=fffe", perf_stalls); end
        drive(1'b1, 3'd5, 3'd2, 1'b1, 1'b1, 3'd7, 1'b1, 16'h7777, 16'h8888);
        rst = 1'b1; ex_stall = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        idle();
        total++; if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_rd !== 3'd0 || ex_op1 !== 16'h0000 || ex_op2 !== 16'h0000) begin
            bad++; $display("FAIL midrst_ex got=%0h/%0h/%0d/%h/%h want=0/0/0/0000/0000", ex_valid, ex_we, ex_rd, ex_op1, ex_op2);
        end
        total++; if (perf_stalls !== 16'h0000 || id_stall !== 1'b0) begin bad++; $display("FAIL midrst_perf got=%h/%0h want=0000/0", perf_stalls, id_stall); end
        drain();
    endtask

    task automatic test_saturate();
        preload_perf();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0055, 16'h0066);
        tick();
        drive(1'b1, 3'd5, 3'd5, 1'b1, 1'b1, 3'd7, 1'b1, 16'h7777, 16'h8888);
        tick();
        total++; if (perf_stalls !== 16'hFFFF) begin bad++; $display("FAIL sat_first got=%h want=ffff", perf_stalls); end
        tick();
        total++; if (perf_stalls !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", perf_stalls); end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_rs = 3'd0; id_rt = 3'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_rd = 3'd0; id_we = 1'b0; rf_read1data = 16'h0000; rf_read2data = 16'h0000;
        test_reset();
        test_independent();
        test_raw1();
        test_raw2_unused();
        test_ex_stall();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (input, 1) and rst (input, 1).
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decoded instruction present
- id_rs, id_rt  in  3 each  source register selects
- id_use_rs, id_use_rt  in  1 each  source actually read
- id_rd  in  3  destination register
- id_we  in  1  instruction writes id_rd
- rf_read1data, rf_read2data  in  16 each  register-file-with-bypass read data
- ex_stall  in  1  downstream EX/MEM hold
- flush  in  1  squash ID instruction (taken branch)
- rf_read1regsel, rf_read2regsel  out  3 each  read selects
- id_stall  out  1  hold fetch/decode
- ex_valid  out  1  EX latch valid
- ex_we  out  1  EX latch write enable
- ex_rd  out  3  EX latch destination
- ex_op1, ex_op2  out  16 each  EX operands
- perf_stalls  out  16  hazard-stall cycle count

Function
REQ-003 SHALL drive rf_read1regsel = id_rs and rf_read2regsel = id_rt combinationally.
REQ-004 SHALL track two pending-write slots: EX (ex_valid, ex_we, ex_rd) and MEM (mem_v, mem_we, mem_rd, internal); the WB-stage write is covered by the register file bypass and is not tracked.
REQ-005 SHALL define match(r) = (ex_valid & ex_we & ex_rd==r) | (mem_v & mem_we & mem_rd==r); r0 is an ordinary register and is not exempt.
REQ-006 SHALL compute hazard = id_valid & ((id_use_rs & match(id_rs)) | (id_use_rt & match(id_rt))), combinationally.
REQ-007 SHALL drive id_stall = hazard | ex_stall, combinationally.
REQ-008 When ex_stall=1, SHALL hold the EX latch, the MEM slot and perf_stalls unchanged; flush is ignored in that cycle.
REQ-009 When ex_stall=0, SHALL load the MEM slot from the EX latch (mem_v<=ex_valid, mem_we<=ex_we, mem_rd<=ex_rd) every cycle.
REQ-010 When ex_stall=0, flush=0, id_valid=1 and hazard=0, SHALL load ex_valid=1, ex_we=id_we, ex_rd=id_rd, ex_op1=rf_read1data and ex_op2=rf_read2data (issue latency 1 cycle).
REQ-011 When ex_stall=0 and (flush=1, id_valid=0, or hazard=1), SHALL load a bubble: ex_valid=0, ex_we=0; ex_rd, ex_op1 and ex_op2 hold.
REQ-012 Flush SHALL take priority over issue and over the hazard decision.
REQ-013 SHALL increment perf_stalls when ex_stall=0, flush=0 and hazard=1, saturating at 0xFFFF with no wrap.
REQ-014 A dependent instruction SHALL stall at most 2 cycles behind a producer when ex_stall=0 throughout.
REQ-015 An instruction with id_we=0 SHALL never cause a hazard, even when id_rd matches a source.

Reset
REQ-016 On rst=1 at a clk edge, SHALL clear ex_valid, ex_we, ex_rd, ex_op1, ex_op2, mem_v, mem_we, mem_rd and perf_stalls to 0, overriding ex_stall and flush.
REQ-017 In the first cycle after reset, SHALL report hazard=0 for any input combination.

Structure
REQ-018 SHALL take register-select width (3), data width (16) and counter width (16) from the shared processor constants package.
REQ-019 SHALL implement match() as one sub-module, reg_match, instantiated once per source operand.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Independent issue: ID writes r3 (id_we=1); next ID reads r4 with rf data 0x1234/0xABCD -> no stall; the cycle after, ex_op1=0x1234 and ex_op2=0xABCD.
- RAW distance 1: producer writes r5; next ID has id_use_rs=1, id_rs=5 -> id_stall=1 for 2 cycles, bubbles enter EX, issue in cycle 3, perf_stalls=2.
- RAW distance 2, plus an unused source: one independent instruction in between -> 1 stall cycle. Separately, id_use_rt=0 with id_rt=5 -> no stall.
- ex_stall held 3 cycles with a pending hazard -> EX latch, MEM slot and perf_stalls frozen; id_stall=1 throughout.
- Flush with id_valid=1 -> ex_valid=0 next cycle. Flush with ex_stall=1 -> no effect.
- Reset mid-stall: perf_stalls=0xFFFE, then hazard, then rst -> all outputs 0. Separately, two more hazard cycles from 0xFFFE -> counter saturates at 0xFFFF.
